// File: rtl/ram_scan_ctrl.sv
// Control stage for the RAM / 7-segment path. It either fills the RAM with a seeded ramp, or scans it and holds each word for DWELL cycles.
// Define RAM_SCAN_VERIFY_EN to build the read-back compare that drives error_o.
module ram_scan_ctrl #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int DWELL  = 2500000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic              stop_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              rden_o,
  output logic              wren_o,
  output logic [DATA_W-1:0] dato_write_o,
  input  logic [DATA_W-1:0] dato_read_i,
  output logic [DATA_W-1:0] disp_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              error_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_RD_REQ = 3'd2;
  localparam logic [2:0] S_RD_CAP = 3'd3;
  localparam logic [2:0] S_DWELL  = 3'd4;

  localparam int                CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0]  DWELL_LOAD = CNT_W'(DWELL - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = '1;

  // Ramp value stored at address a: (a + seed) mod 2^DATA_W.
  function automatic logic [DATA_W-1:0] ramp_word(input logic [ADDR_W-1:0] a,
                                                  input logic [DATA_W-1:0] s);
    return DATA_W'(a) + s;
  endfunction

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] seed_q,  seed_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              stop_q,  stop_d;
  logic [DATA_W-1:0] disp_q,  disp_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wren_q,  wren_d;
  logic              rden_q,  rden_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;
  logic [ADDR_W-1:0] addr_inc;

  assign addr_inc = addr_q + ADDR_W'(1);

  // Outputs are computed for the state being entered, then registered.
  always_comb begin
    // NOTE: every _d gets a default before the case, so no path can infer a latch.
    state_d = state_q;
    addr_d  = addr_q;
    seed_d  = seed_q;
    cnt_d   = cnt_q;
    stop_d  = stop_q;
    disp_d  = disp_q;
    wdata_d = '0;
    wren_d  = 1'b0;
    rden_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          seed_d = seed_i;
          addr_d = '0;
          stop_d = 1'b0;
          if (mode_i) begin
            state_d = S_RD_REQ;
            rden_d  = 1'b1;
          end else begin
            state_d = S_FILL;
            wren_d  = 1'b1;
            wdata_d = ramp_word('0, seed_i);
          end
        end
      end
      S_FILL: begin
        if (addr_q == ADDR_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          addr_d  = addr_inc;
          wren_d  = 1'b1;
          wdata_d = ramp_word(addr_inc, seed_q);
        end
      end
      S_RD_REQ: begin
        state_d = S_RD_CAP;
        stop_d  = stop_q | stop_i;
      end
      S_RD_CAP: begin
        state_d = S_DWELL;
        disp_d  = dato_read_i;
        cnt_d   = DWELL_LOAD;
        stop_d  = stop_q | stop_i;
      end
      S_DWELL: begin
        stop_d = stop_q | stop_i;
        if (cnt_q == '0) begin
          // A stop seen anywhere in this word's scan slot ends the scan here.
          if (stop_q | stop_i) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RD_REQ;
            addr_d  = addr_inc;
            rden_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      seed_q  <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      disp_q  <= '0;
      wdata_q <= '0;
      wren_q  <= 1'b0;
      rden_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      addr_q  <= addr_d;
      seed_q  <= seed_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      disp_q  <= disp_d;
      wdata_q <= wdata_d;
      wren_q  <= wren_d;
      rden_q  <= rden_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign addr_o       = addr_q;
  assign rden_o       = rden_q;
  assign wren_o       = wren_q;
  assign dato_write_o = wdata_q;
  assign disp_o       = disp_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

`ifdef RAM_SCAN_VERIFY_EN
  logic error_q, error_d;

  // The scanned word must match the ramp that FILL would have written with the scan's seed.
  always_comb begin
    error_d = error_q;
    if (state_q == S_IDLE && start_i) begin
      error_d = 1'b0;
    end else if (state_q == S_RD_CAP && dato_read_i != ramp_word(addr_q, seed_q)) begin
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) error_q <= 1'b0;
    else        error_q <= error_d;
  end

  assign error_o = error_q;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_ram_scan_ctrl.sv
// Self-checking bench for ram_scan_ctrl with a 1-cycle-read RAM model and a timeline-based scan model.
module tb_ram_scan_ctrl;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 4;
  localparam int DWELL  = 4;
  localparam int DEPTH  = 16;
  localparam int PERIOD = DWELL + 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start_i, mode_i, stop_i;
  logic [DATA_W-1:0] seed_i;
  logic [ADDR_W-1:0] addr;
  logic              rden, wren, busy, done, error;
  logic [DATA_W-1:0] wdata, rdata, disp;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ram_scan_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DWELL(DWELL)) dut (
    .clk_i(clk), .rst_i(rst_n), .start_i(start_i), .mode_i(mode_i), .stop_i(stop_i),
    .seed_i(seed_i), .addr_o(addr), .rden_o(rden), .wren_o(wren), .dato_write_o(wdata),
    .dato_read_i(rdata), .disp_o(disp), .busy_o(busy), .done_o(done), .error_o(error)
  );

  // RAM environment: synchronous write, registered read; corrupt_rd flips the word at addr 9.
  logic [DATA_W-1:0] mem [DEPTH];
  bit                corrupt_rd = 1'b0;
  always @(posedge clk) begin
    if (wren) mem[addr] <= wdata;
    if (rden) rdata <= (corrupt_rd && addr == 4'd9) ? ~mem[addr] : mem[addr];
  end

  // Expected RAM content and observable state, derived from the ramp/scan rules.
  logic [DATA_W-1:0] ram_exp [DEPTH];
  logic [DATA_W-1:0] exp_disp = '0;
  logic              exp_err  = 1'b0;
  logic [DATA_W-1:0] cur_seed = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  typedef struct {
    logic              start, mode, stop;
    logic [DATA_W-1:0] seed;
    logic              e_busy, e_wren, e_done;
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_wdata;
  } vec_t;
  vec_t vecs [18];

  task automatic fill_run(input logic [DATA_W-1:0] seed, input bit noise);
    start_i = 1'b1; mode_i = 1'b0; seed_i = seed; stop_i = 1'b0;
    cur_seed = seed;
    exp_err  = 1'b0;
    for (int t = 0; t <= DEPTH; t++) begin
      @(negedge clk);
      if (t < DEPTH) begin
        check("fill_busy", busy, 1);
        check("fill_wren", wren, 1);
        check("fill_rden", rden, 0);
        check("fill_done", done, 0);
        check("fill_addr", addr, t);
        check("fill_data", wdata, 4'((t + seed) % 16));
        ram_exp[t] = 4'((t + seed) % 16);
      end else begin
        check("fill_end_done", done, 1);
        check("fill_end_busy", busy, 0);
        check("fill_end_wren", wren, 0);
      end
      check("fill_error", error, exp_err);
      start_i = (noise && t < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      stop_i  = (noise && t < DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
      mode_i  = 1'($urandom);
      seed_i  = 4'($urandom);
    end
    start_i = 1'b0; stop_i = 1'b0;
    @(negedge clk);
    check("fill_done_pulse", done, 0);
    check("fill_idle_busy", busy, 0);
  endtask

  // Word k of a scan occupies cycles k*PERIOD .. k*PERIOD+PERIOD-1 after start; phase 0 is the read request.
  task automatic scan_run(input int stop_word, input int stop_phase, input bit noise, input bit corrupt);
    bit stop_seen = 1'b0;
    bit finishing = 1'b0;
    bit ended     = 1'b0;
    int k, ph, a;
    logic [DATA_W-1:0] v;
    corrupt_rd = corrupt;
    start_i = 1'b1; mode_i = 1'b1; seed_i = cur_seed; stop_i = 1'b0;
    exp_err = 1'b0;
    for (int t = 0; t < 2000; t++) begin
      @(negedge clk);
      if (finishing) begin
        check("scan_done", done, 1);
        check("scan_end_busy", busy, 0);
        check("scan_end_rden", rden, 0);
        check("scan_end_disp", disp, exp_disp);
        check("scan_end_error", error, exp_err);
        ended = 1'b1;
        break;
      end
      k  = t / PERIOD;
      ph = t % PERIOD;
      a  = k % DEPTH;
      if (ph == 2) begin
        v = ram_exp[a];
        if (corrupt && a == 9) v = ~v;
        exp_disp = v;
`ifdef RAM_SCAN_VERIFY_EN
        if (corrupt && a == 9) exp_err = 1'b1;
`endif
      end
      check("scan_busy", busy, 1);
      check("scan_done_low", done, 0);
      check("scan_wren", wren, 0);
      check("scan_rden", rden, (ph == 0));
      if (ph == 0) check("scan_addr", addr, a);
      check("scan_disp", disp, exp_disp);
      check("scan_error", error, exp_err);
      stop_i  = (k == stop_word && ph == stop_phase);
      if (stop_i) stop_seen = 1'b1;
      start_i = noise ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      mode_i  = 1'($urandom);
      seed_i  = 4'($urandom);
      if (stop_seen && ph == PERIOD - 1) finishing = 1'b1;
    end
    if (!ended) check("scan_timeout", 0, 1);
    start_i = 1'b0; stop_i = 1'b0; mode_i = 1'b0;
    corrupt_rd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_scan_busy", busy, 0);
      check("post_scan_done", done, 0);
      check("post_scan_rden", rden, 0);
      check("post_scan_disp", disp, exp_disp);
      check("post_scan_error", error, exp_err);
    end
  endtask

  task automatic reset_mid_fill();
    start_i = 1'b1; mode_i = 1'b0; seed_i = 4'd5; stop_i = 1'b0;
    for (int t = 0; t <= 5; t++) begin
      @(negedge clk);
      start_i = 1'b0;
      check("rstfill_addr", addr, t);
      check("rstfill_wren", wren, 1);
      if (t < 5) ram_exp[t] = 4'((t + 5) % 16);
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_wren", wren, 0);
    check("rst_rden", rden, 0);
    check("rst_addr", addr, 0);
    check("rst_wdata", wdata, 0);
    check("rst_disp", disp, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    exp_disp = '0;
    exp_err  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_rel_busy", busy, 0);
      check("rst_rel_done", done, 0);
      check("rst_rel_wren", wren, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 18; i++) begin
      vecs[i].start   = (i == 0) || (i == 7);
      vecs[i].mode    = (i != 0);
      vecs[i].stop    = (i == 5);
      vecs[i].seed    = (i == 0) ? 4'd3 : 4'd9;
      vecs[i].e_busy  = (i < 16);
      vecs[i].e_wren  = (i < 16);
      vecs[i].e_done  = (i == 16);
      vecs[i].e_addr  = 4'(i);
      vecs[i].e_wdata = 4'((i + 3) % 16);
    end

    rst_n = 1'b0; start_i = 1'b0; mode_i = 1'b0; stop_i = 1'b0; seed_i = '0;
    #3;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_wren", wren, 0);
    check("reset_rden", rden, 0);
    check("reset_addr", addr, 0);
    check("reset_wdata", wdata, 0);
    check("reset_disp", disp, 0);
    check("reset_error", error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // FILL seed 3 with an ignored start (SCAN) and an ignored stop mid-fill.
    for (int i = 0; i < 18; i++) begin
      start_i = vecs[i].start; mode_i = vecs[i].mode;
      stop_i  = vecs[i].stop;  seed_i = vecs[i].seed;
      @(negedge clk);
      check("vec_busy", busy, vecs[i].e_busy);
      check("vec_wren", wren, vecs[i].e_wren);
      check("vec_rden", rden, 0);
      check("vec_done", done, vecs[i].e_done);
      check("vec_error", error, 0);
      if (vecs[i].e_wren) begin
        check("vec_addr", addr, vecs[i].e_addr);
        check("vec_wdata", wdata, vecs[i].e_wdata);
      end
    end
    start_i = 1'b0; stop_i = 1'b0; mode_i = 1'b0;
    for (int a = 0; a < DEPTH; a++) ram_exp[a] = 4'((a + 3) % 16);
    cur_seed = 4'd3;

    // Scan past the 15->0 wrap with start noise, stop mid-dwell at addr 7.
    scan_run(DEPTH + 7, 3, 1'b1, 1'b0);

    reset_mid_fill();

    // Corrupted read at addr 9, then a new start clears the error.
    fill_run(4'hC, 1'b1);
    scan_run(11, 2, 1'b0, 1'b1);
    fill_run(4'h6, 1'b0);

    for (int it = 0; it < 4; it++) begin
      fill_run(4'($urandom), 1'b1);
      scan_run($urandom_range(0, 20), $urandom_range(1, PERIOD - 1), 1'b1, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
